// File: rtl/perf_counter_bank.sv
// Bank of NUM_EVENTS event counters with a snapshot shadow bank and a one-cycle-latency read port.
// Optional sticky per-counter wrap flags are built only when PERF_CNT_OVERFLOW_IRQ_EN is defined.
module perf_counter_bank #(
  parameter int NUM_EVENTS = 16,
  parameter int CNT_WIDTH  = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_EVENTS-1:0] event_in,
  input  logic [NUM_EVENTS-1:0] edge_mode,
  input  logic                  global_en,
  input  logic                  clr_req,
  input  logic [ADDR_WIDTH-1:0] clr_addr,
  input  logic                  clr_all,
  input  logic                  snap_req,
  input  logic                  rd_req,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic                  rd_shadow,
  output logic                  rd_valid,
  output logic [CNT_WIDTH-1:0]  rd_data,
  output logic [NUM_EVENTS-1:0] ovf_flags,
  output logic                  ovf_irq
);

  logic [NUM_EVENTS-1:0] prev_q, prev_d;
  logic [NUM_EVENTS-1:0] inc;
  logic [NUM_EVENTS-1:0] clr_hit;
  logic [CNT_WIDTH-1:0]  cnt_q    [NUM_EVENTS];
  logic [CNT_WIDTH-1:0]  cnt_d    [NUM_EVENTS];
  logic [CNT_WIDTH-1:0]  shadow_q [NUM_EVENTS];
  logic [CNT_WIDTH-1:0]  shadow_d [NUM_EVENTS];
  logic [CNT_WIDTH-1:0]  rd_sel;
  logic                  rd_valid_q, rd_valid_d;
  logic [CNT_WIDTH-1:0]  rd_data_q, rd_data_d;

  // Counting: edge-mode channels only count the first cycle of each assertion run.
  // A clear of a counter always beats a same-cycle increment.
  always_comb begin
    prev_d   = event_in;
    inc      = '0;
    clr_hit  = '0;
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    for (int i = 0; i < NUM_EVENTS; i++) begin
      inc[i]      = global_en & event_in[i] & (~edge_mode[i] | ~prev_q[i]);
      clr_hit[i]  = clr_all | (clr_req & (clr_addr == ADDR_WIDTH'(i)));
      cnt_d[i]    = clr_hit[i] ? '0 : cnt_q[i] + CNT_WIDTH'(inc[i]);
      shadow_d[i] = snap_req ? cnt_q[i] : shadow_q[i];
    end
  end

  // Read port: rd_req is a valid-only request (no ready, never stalls); the response appears
  // with rd_valid exactly one cycle later. Out-of-range addresses match no entry and return 0.
  always_comb begin
    rd_sel = '0;
    for (int i = 0; i < NUM_EVENTS; i++) begin
      if (rd_addr == ADDR_WIDTH'(i)) begin
        rd_sel = rd_shadow ? shadow_q[i] : cnt_q[i];
      end
    end
    rd_valid_d = rd_req;
    rd_data_d  = rd_req ? rd_sel : rd_data_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prev_q     <= '0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      for (int i = 0; i < NUM_EVENTS; i++) begin
        cnt_q[i]    <= '0;
        shadow_q[i] <= '0;
      end
    end else begin
      prev_q     <= prev_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
      cnt_q      <= cnt_d;
      shadow_q   <= shadow_d;
    end
  end

  assign rd_valid = rd_valid_q;
  assign rd_data  = rd_data_q;

`ifdef PERF_CNT_OVERFLOW_IRQ_EN
  logic [NUM_EVENTS-1:0] ovf_q, ovf_d;

  // A flag sets on wrap and stays until its counter is cleared; a clear in the wrap cycle wins.
  always_comb begin
    ovf_d = '0;
    for (int i = 0; i < NUM_EVENTS; i++) begin
      ovf_d[i] = ~clr_hit[i] & (ovf_q[i] | (inc[i] & (&cnt_q[i])));
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ovf_q <= '0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign ovf_flags = ovf_q;
  assign ovf_irq   = |ovf_q;
`else
  assign ovf_flags = '0;
  assign ovf_irq   = 1'b0;
`endif

endmodule

// File: tb/tb_perf_counter_bank.sv
// Directed bench for perf_counter_bank (16 channels, 8-bit counters).
// Expected flag values follow PERF_CNT_OVERFLOW_IRQ_EN as defined for the build.
module tb_perf_counter_bank;

  localparam int NE = 16;
  localparam int CW = 8;
  localparam int AW = 5;
`ifdef PERF_CNT_OVERFLOW_IRQ_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  logic          clk;
  logic          rst_n;
  logic [NE-1:0] event_in;
  logic [NE-1:0] edge_mode;
  logic          global_en;
  logic          clr_req;
  logic [AW-1:0] clr_addr;
  logic          clr_all;
  logic          snap_req;
  logic          rd_req;
  logic [AW-1:0] rd_addr;
  logic          rd_shadow;
  logic          rd_valid;
  logic [CW-1:0] rd_data;
  logic [NE-1:0] ovf_flags;
  logic          ovf_irq;

  int total = 0;
  int bad   = 0;
  logic [CW-1:0] exp_q[$];

  perf_counter_bank #(.NUM_EVENTS(NE), .CNT_WIDTH(CW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst_n(rst_n), .event_in(event_in), .edge_mode(edge_mode),
    .global_en(global_en), .clr_req(clr_req), .clr_addr(clr_addr), .clr_all(clr_all),
    .snap_req(snap_req), .rd_req(rd_req), .rd_addr(rd_addr), .rd_shadow(rd_shadow),
    .rd_valid(rd_valid), .rd_data(rd_data), .ovf_flags(ovf_flags), .ovf_irq(ovf_irq)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    int          ch;
    logic        em;
    logic [15:0] ev;
    logic [15:0] en;
    int          len;
    logic [7:0]  exp;
    string       name;
  } vec_t;

  vec_t vecs[7];

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic check_read(input string name, input int addr, input logic shadow,
                            input logic [CW-1:0] exp);
    exp_q.push_back(exp);
    rd_req    = 1'b1;
    rd_addr   = AW'(addr);
    rd_shadow = shadow;
    tick();
    rd_req    = 1'b0;
    rd_shadow = 1'b0;
    check({name, "_valid"}, 64'(rd_valid), 64'd1);
    check(name, 64'(rd_data), 64'(exp_q.pop_front()));
  endtask

  task automatic clear_all_cnt();
    event_in = '0;
    clr_all  = 1'b1;
    tick();
    clr_all  = 1'b0;
  endtask

  initial begin
    vecs[0] = '{ch:2, em:1'b1, ev:16'h01DF, en:16'hFFFF, len:9,  exp:8'd2, name:"edge_runs"};
    vecs[1] = '{ch:2, em:1'b0, ev:16'h01DF, en:16'hFFFF, len:9,  exp:8'd8, name:"level_runs"};
    vecs[2] = '{ch:0, em:1'b0, ev:16'h03FF, en:16'h01B3, len:10, exp:8'd6, name:"gated_level"};
    vecs[3] = '{ch:5, em:1'b1, ev:16'h0055, en:16'hFFFF, len:8,  exp:8'd4, name:"edge_alt"};
    vecs[4] = '{ch:5, em:1'b0, ev:16'h0055, en:16'hFFFF, len:8,  exp:8'd4, name:"level_alt"};
    vecs[5] = '{ch:7, em:1'b1, ev:16'h00FF, en:16'hFFFC, len:8,  exp:8'd0, name:"edge_gated_prev"};
    vecs[6] = '{ch:6, em:1'b1, ev:16'h002F, en:16'hFFFF, len:6,  exp:8'd2, name:"edge_gap"};

    rst_n = 1'b0; event_in = '0; edge_mode = '0; global_en = 1'b0;
    clr_req = 1'b0; clr_addr = '0; clr_all = 1'b0; snap_req = 1'b0;
    rd_req = 1'b0; rd_addr = '0; rd_shadow = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;

    check("rst_rd_valid", 64'(rd_valid), 64'd0);
    check("rst_rd_data", 64'(rd_data), 64'd0);
    check("rst_ovf_flags", 64'(ovf_flags), 64'd0);
    check("rst_ovf_irq", 64'(ovf_irq), 64'd0);
    check_read("rst_cnt0", 0, 1'b0, 8'd0);
    check_read("rst_shadow9", 9, 1'b1, 8'd0);

    // table-driven event patterns, bit j of ev/en is applied in cycle j
    for (int v = 0; v < 7; v++) begin
      global_en = 1'b1;
      edge_mode = '0;
      edge_mode[vecs[v].ch] = vecs[v].em;
      clear_all_cnt();
      for (int j = 0; j < vecs[v].len; j++) begin
        event_in = '0;
        event_in[vecs[v].ch] = vecs[v].ev[j];
        global_en = vecs[v].en[j];
        tick();
      end
      event_in  = '0;
      global_en = 1'b1;
      check_read(vecs[v].name, vecs[v].ch, 1'b0, vecs[v].exp);
    end

    // wrap of an 8-bit counter
    edge_mode = '0;
    clear_all_cnt();
    event_in[1] = 1'b1;
    for (int j = 0; j < 255; j++) tick();
    event_in = '0;
    check_read("wrap_pre", 1, 1'b0, 8'd255);
    check("wrap_pre_flags", 64'(ovf_flags), 64'd0);
    event_in[1] = 1'b1;
    tick();
    event_in = '0;
    check_read("wrap_post", 1, 1'b0, 8'd0);
    check("wrap_flags", 64'(ovf_flags), OVF_EN ? 64'h2 : 64'h0);
    check("wrap_irq", 64'(ovf_irq), 64'(OVF_EN));
    tick();
    check("wrap_flag_sticky", 64'(ovf_flags), OVF_EN ? 64'h2 : 64'h0);
    clr_req = 1'b1; clr_addr = 5'd1;
    tick();
    clr_req = 1'b0;
    check("wrap_flag_cleared", 64'(ovf_flags), 64'd0);
    check("wrap_irq_cleared", 64'(ovf_irq), 64'd0);

    // clear + increment + read of the same counter in one cycle
    clear_all_cnt();
    event_in[3] = 1'b1;
    for (int j = 0; j < 4; j++) tick();
    clr_req = 1'b1; clr_addr = 5'd3; rd_req = 1'b1; rd_addr = 5'd3; rd_shadow = 1'b0;
    tick();
    clr_req = 1'b0; rd_req = 1'b0; event_in = '0;
    check("clr_rd_valid", 64'(rd_valid), 64'd1);
    check("clr_rd_data", 64'(rd_data), 64'd4);
    tick();
    check("idle_rd_valid", 64'(rd_valid), 64'd0);
    check("idle_rd_hold", 64'(rd_data), 64'd4);
    check_read("clr_cnt3", 3, 1'b0, 8'd0);

    // snapshot, further counting, out-of-range accesses
    clear_all_cnt();
    event_in[4] = 1'b1;
    for (int j = 0; j < 10; j++) tick();
    event_in = '0;
    snap_req = 1'b1;
    tick();
    snap_req = 1'b0;
    event_in[4] = 1'b1;
    for (int j = 0; j < 5; j++) tick();
    event_in = '0;
    check_read("snap_shadow4", 4, 1'b1, 8'd10);
    check_read("snap_live4", 4, 1'b0, 8'd15);
    check_read("rd_oob31", 31, 1'b0, 8'd0);
    clr_req = 1'b1; clr_addr = 5'd20;
    tick();
    clr_req = 1'b0;
    check_read("clr_oob_live4", 4, 1'b0, 8'd15);
    clear_all_cnt();
    check_read("clrall_shadow4", 4, 1'b1, 8'd10);
    check_read("clrall_live4", 4, 1'b0, 8'd0);

    // reset mid-count with a read pending
    event_in[0] = 1'b1;
    for (int j = 0; j < 3; j++) tick();
    rst_n = 1'b0; rd_req = 1'b1; rd_addr = 5'd0;
    tick();
    rst_n = 1'b1; rd_req = 1'b0; event_in = '0;
    check("rst_mid_rd_valid", 64'(rd_valid), 64'd0);
    check("rst_mid_rd_data", 64'(rd_data), 64'd0);
    check_read("rst_mid_cnt0", 0, 1'b0, 8'd0);
    check_read("rst_mid_shadow4", 4, 1'b1, 8'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/perf_counter_bank.md
PERF_COUNTER_BANK -- requirements
Module: perf_counter_bank

Interface
REQ-001 The block SHALL have a parameter NUM_EVENTS, default 16, giving the number of event channels (1..32).
REQ-002 The block SHALL have a parameter CNT_WIDTH, default 32, giving the width of each counter (8..64).
REQ-003 The block SHALL have a parameter ADDR_WIDTH, default 5, giving the counter index width; 2**ADDR_WIDTH >= NUM_EVENTS.
REQ-004 The block SHALL have port clk, input, width 1: the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst_n, input, width 1: reset, synchronous and active-low.
REQ-006 The block SHALL have port event_in, input, width NUM_EVENTS: per-channel event strobes.
REQ-007 The block SHALL have port edge_mode, input, width NUM_EVENTS: per channel, 1 = count assertion runs, 0 = count asserted cycles.
REQ-008 The block SHALL have port global_en, input, width 1: counting enable, 0 = freeze all counters.
REQ-009 The block SHALL have port clr_req, input, width 1: clear the counter selected by clr_addr.
REQ-010 The block SHALL have port clr_addr, input, width ADDR_WIDTH: index of the counter to clear.
REQ-011 The block SHALL have port clr_all, input, width 1: clear all counters.
REQ-012 The block SHALL have port snap_req, input, width 1: copy all live counters into the shadow bank.
REQ-013 The block SHALL have port rd_req, input, width 1: read request.
REQ-014 The block SHALL have port rd_addr, input, width ADDR_WIDTH: read index.
REQ-015 The block SHALL have port rd_shadow, input, width 1: 1 = read the shadow bank, 0 = read the live bank.
REQ-016 The block SHALL have port rd_valid, output, width 1: read data valid.
REQ-017 The block SHALL have port rd_data, output, width CNT_WIDTH: read result.
REQ-018 The block SHALL have port ovf_flags, output, width NUM_EVENTS: sticky per-counter overflow flags.
REQ-019 The block SHALL have port ovf_irq, output, width 1: OR of ovf_flags.

Function
REQ-020 Counter i SHALL increment by 1 in a cycle when global_en & event_in[i] & (~edge_mode[i] | ~prev[i]) holds, where prev[i] is event_in[i] registered in the previous cycle.
REQ-021 prev[i] SHALL update every cycle, independent of global_en, clears and reads.
REQ-022 Increment SHALL be modulo 2**CNT_WIDTH: an all-ones counter becomes 0.
REQ-023 If clr_req is high and clr_addr < NUM_EVENTS, counter clr_addr SHALL be 0 after the edge, overriding any same-cycle increment; if clr_addr >= NUM_EVENTS, clr_req SHALL have no effect.
REQ-024 clr_all SHALL zero every live counter after the edge, overriding increments and clr_req; clr_all SHALL NOT affect the shadow bank.
REQ-025 snap_req SHALL load shadow[i] with the pre-edge live value of counter i, for all i, in the same edge.
REQ-026 rd_req at edge N SHALL give rd_valid = 1 and rd_data = the pre-edge-N value of the selected bank entry, both during cycle N+1 (one-cycle latency).
REQ-027 rd_valid SHALL be 0 in any cycle that does not follow an rd_req cycle; rd_data SHALL hold its last value when rd_valid = 0.
REQ-028 A read with rd_addr >= NUM_EVENTS SHALL return rd_valid = 1 and rd_data = 0.
REQ-029 Back-to-back rd_req SHALL be accepted every cycle with no stalls.

Reset
REQ-030 While rst_n = 0 at a clock edge, all live counters, the shadow bank, prev, rd_valid, rd_data, ovf_flags and ovf_irq SHALL become 0.
REQ-031 Reset SHALL take priority over every other input; a read requested in the reset cycle SHALL be dropped.

Configuration
REQ-032 With macro PERF_CNT_OVERFLOW_IRQ_EN defined, ovf_flags[i] SHALL set on each wrap of counter i, SHALL stay set, and SHALL clear only on a clear of that counter (clr_req or clr_all) or on reset; a clear in the same cycle as a wrap SHALL leave the flag 0.
REQ-033 Without PERF_CNT_OVERFLOW_IRQ_EN, ovf_flags and ovf_irq SHALL be constant 0, the ports SHALL still exist, and no flag storage SHALL be built.

Verification
REQ-034 The bench SHALL cover: edge_mode[2] = 1, event_in[2] high for 5 cycles, low 1 cycle, high 3 cycles -> counter 2 = 2; with edge_mode[2] = 0 -> counter 2 = 8.
REQ-035 The bench SHALL cover: event_in[0] held high, global_en = 0 for 4 of 10 cycles -> counter 0 = 6.
REQ-036 The bench SHALL cover: CNT_WIDTH = 8, counter 1 preloaded via 255 events, one more event -> counter reads 0, ovf_flags[1] = 1 and ovf_irq = 1 when the macro is defined, and both 0 when it is undefined.
REQ-037 The bench SHALL cover: clr_req with clr_addr = 3 in the same cycle as an increment and an rd_req to address 3 -> rd_data = pre-clear value one cycle later, counter 3 = 0 afterwards.
REQ-038 The bench SHALL cover: counter 4 = 10, snap_req, then 5 more events, rd_shadow = 1 -> 10, rd_shadow = 0 -> 15; rd_addr = 31 with NUM_EVENTS = 16 -> rd_valid = 1, rd_data = 0.
REQ-039 The bench SHALL cover: rst_n low for one edge mid-count while rd_req = 1 -> all counters 0 and rd_valid = 0 on the next cycle.
